// File: rtl/life_seed_loader.sv
// Seeding stage for the 8x8 Game of Life engine. Builds a 64-cell board from a
// slow asynchronous serial stream or a built-in preset, then offers it to the
// engine with a req/ack handshake.
module life_seed_loader #(
    parameter int unsigned SIZE        = 64,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_ser_clk,
    input  logic            i_ser_data,
    input  logic            i_ser_latch,
    input  logic [1:0]      i_preset_sel,
    input  logic            i_preset_go,
    input  logic            i_board_ack,
    output logic            o_board_req,
    output logic [SIZE-1:0] o_board_data,
    output logic            o_busy,
    output logic            o_err_short
);

    localparam int unsigned CW = $clog2(SIZE + 1);
    localparam int unsigned NP = 6;

    typedef enum logic [1:0] {StIdle, StShift, StPend} state_t;

    // Pin bundle order: {preset_sel[1:0], preset_go, ser_latch, ser_data, ser_clk}
    logic [NP-1:0]                  w_pins;
    logic [SYNC_STAGES-1:0][NP-1:0] r_sync;
    logic [NP-1:0]                  w_pins_s;
    logic [2:0]                     r_hist;

    logic            w_clk_rise;
    logic            w_latch_rise;
    logic            w_go_rise;
    logic            w_data_s;
    logic [1:0]      w_sel_s;

    state_t          r_state;
    logic [SIZE-1:0] r_sr;
    logic [CW-1:0]   r_cnt;
    logic [SIZE-1:0] r_board;
    logic            r_req;
    logic            r_busy;
    logic            r_err;

    logic [SIZE-1:0] w_sr_nx;
    logic [CW-1:0]   w_cnt_nx;
    logic [SIZE-1:0] w_preset;

    assign w_pins   = {i_preset_sel, i_preset_go, i_ser_latch, i_ser_data, i_ser_clk};
    assign w_pins_s = r_sync[SYNC_STAGES-1];
    assign w_data_s = w_pins_s[1];
    assign w_sel_s  = w_pins_s[5:4];

    // Synchronizer chain and edge-detect history; both preset to 1 so a pin held
    // high through reset produces no edge.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_sync <= '1;
            r_hist <= '1;
        end else begin
            r_sync[0] <= w_pins;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_hist <= {w_pins_s[3], w_pins_s[2], w_pins_s[0]};
        end
    end

    // Rising edges of the synchronized control pins.
    always_comb begin
        w_clk_rise   = w_pins_s[0] & ~r_hist[0];
        w_latch_rise = w_pins_s[2] & ~r_hist[1];
        w_go_rise    = w_pins_s[3] & ~r_hist[2];
    end

    // Shift-then-commit: a bit arriving with the latch edge is shifted first and
    // the commit check sees the updated count and register.
    always_comb begin
        w_sr_nx  = r_sr;
        w_cnt_nx = r_cnt;
        if (w_clk_rise) begin
            w_sr_nx  = {w_data_s, r_sr[SIZE-1:1]};
            w_cnt_nx = (r_cnt == CW'(SIZE)) ? r_cnt : r_cnt + CW'(1);
        end
    end

    // Built-in preset boards.
    always_comb begin
        w_preset = '0;
        unique case (w_sel_s)
            2'd0: w_preset = '0;
            2'd1: w_preset = SIZE'(64'h50A8_8888_0609_0909);
            2'd2: w_preset = SIZE'(64'h0000_0000_0007_0402);
            2'd3: w_preset = SIZE'(64'h0000_0000_3800_0000);
            default: w_preset = '0;
        endcase
    end

    // Main control FSM with registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= StIdle;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_board <= '0;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_latch_rise) begin
                        r_state <= StShift;
                        r_sr    <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end else if (w_go_rise) begin
                        r_state <= StPend;
                        r_board <= w_preset;
                        r_req   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                StShift: begin
                    r_sr  <= w_sr_nx;
                    r_cnt <= w_cnt_nx;
                    if (w_latch_rise) begin
                        if (w_cnt_nx == CW'(SIZE)) begin
                            r_state <= StPend;
                            r_board <= w_sr_nx;
                            r_req   <= 1'b1;
                        end else begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                            r_err   <= 1'b1;
                        end
                    end
                end
                StPend: begin
                    if (i_board_ack) begin
                        r_state <= StIdle;
                        r_req   <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_board_req  = r_req;
    assign o_board_data = r_board;
    assign o_busy       = r_busy;
    assign o_err_short  = r_err;

endmodule
